// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing arithmetic blocks:
// divider FSM encoding and default operand widths.
package img_proc_pkg;

    localparam int DIV_DIVIDEND_W = 16;
    localparam int DIV_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Step counter must hold the value DIVIDEND_W itself.
    function automatic int div_cnt_w(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift one dividend bit into
// the partial remainder, subtract the divisor if it fits.
module div_step
    import img_proc_pkg::*;
#(
    parameter int DIVISOR_W = DIV_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem,
    input  logic                 in_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] trial_s;
    logic [DIVISOR_W+1:0] dvs_ext_s;

    // The incoming rem is always below the divisor, so its MSB is zero and the
    // full-width trial equals {rem[DIVISOR_W-1:0], in_bit}.
    always_comb begin
        trial_s   = {rem, in_bit};
        dvs_ext_s = {2'b00, divisor};
        if (trial_s >= dvs_ext_s) begin
            rem_next = (DIVISOR_W + 1)'(trial_s - dvs_ext_s);
            q_bit    = 1'b1;
        end else begin
            rem_next = trial_s[DIVISOR_W:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_16_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operand and result sides.
module div_16_8
    import img_proc_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                CNT_W    = div_cnt_w(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    div_state_e            state_q;
    logic [DIVIDEND_W-1:0] dvd_sr_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  dvd_low_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  zero_q;
    logic                  out_valid_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  div_by_zero_q;

    logic [DIVISOR_W:0]    rem_next_s;
    logic                  q_bit_s;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem      (rem_q),
        .in_bit   (dvd_sr_q[DIVIDEND_W-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Controller and datapath: accept, iterate DIVIDEND_W steps, publish, hand off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= DIV_IDLE;
            dvd_sr_q      <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            dvd_low_q     <= '0;
            cnt_q         <= '0;
            zero_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (in_valid) begin
                        dvd_sr_q  <= dividend;
                        dvs_q     <= divisor;
                        dvd_low_q <= dividend[DIVISOR_W-1:0];
                        rem_q     <= '0;
                        cnt_q     <= CNT_LOAD;
                        zero_q    <= (divisor == '0);
                        state_q   <= DIV_BUSY;
                    end else begin
                        state_q   <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    // Divide-by-zero runs the same steps so latency stays uniform.
                    if (cnt_q != '0) begin
                        dvd_sr_q <= {dvd_sr_q[DIVIDEND_W-2:0], q_bit_s};
                        rem_q    <= rem_next_s;
                        cnt_q    <= cnt_q - CNT_ONE;
                    end else begin
                        if (zero_q) begin
                            quotient_q    <= '1;
                            remainder_q   <= dvd_low_q;
                            div_by_zero_q <= 1'b1;
                        end else begin
                            quotient_q    <= dvd_sr_q;
                            remainder_q   <= rem_q[DIVISOR_W-1:0];
                            div_by_zero_q <= 1'b0;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DIV_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == DIV_IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_16_8.sv
// Self-checking bench for div_16_8: directed corner cases, backpressure,
// mid-operation reset and a randomized stream against an arithmetic model.
module tb_div_16_8;

    localparam int N_RAND    = 1500;
    localparam int CYC_LIMIT = 60000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    div_16_8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'hFFFF;
        return 16'(int'(a) / int'(b));
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return a[7:0];
        return 8'(int'(a) % int'(b));
    endfunction

    // Issue one operand pair, wait for the result, check latency and values, consume it.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b);
        int   lat;
        logic seen;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat  = i;
            seen = out_valid;
        end
        chk({tag, "_latency"}, lat, 32'd17);
        chk({tag, "_quotient"}, quotient, ref_q(a, b));
        chk({tag, "_remainder"}, remainder, ref_r(a, b));
        chk({tag, "_dbz"}, div_by_zero, (b == 8'd0) ? 32'd1 : 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 32'd0);
        chk({tag, "_ready_back"}, in_ready, 32'd1);
    endtask

    initial begin
        logic [15:0] bp_a;
        logic [7:0]  bp_b;
        logic        seen;
        logic [15:0] eq_q[$];
        logic [7:0]  er_q[$];
        logic        ed_q[$];
        int          sent;
        int          got;
        int          cyc;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", div_by_zero, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        run_div("d1000_7", 16'd1000, 8'd7);
        chk("d1000_7_q_const", quotient, 32'd142);
        run_div("dffff_1", 16'hFFFF, 8'h01);
        run_div("dffff_ff", 16'hFFFF, 8'hFF);
        chk("dffff_ff_q_const", quotient, 32'h0101);
        run_div("d5_10", 16'd5, 8'd10);
        run_div("d0_3", 16'd0, 8'd3);
        run_div("d1234_0", 16'h1234, 8'd0);
        chk("d1234_0_r_const", remainder, 32'h34);
        run_div("d100_9", 16'd100, 8'd9);
        chk("d100_9_q_const", quotient, 32'd11);

        // Backpressure: result must hold while out_ready stays low
        bp_a = 16'hBEEF;
        bp_b = 8'h2D;
        @(negedge clk);
        dividend = bp_a;
        divisor  = bp_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen = out_valid;
        end
        chk("bp_seen", seen, 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", out_valid, 32'd1);
            chk("bp_in_ready", in_ready, 32'd0);
            chk("bp_quotient", quotient, ref_q(bp_a, bp_b));
            chk("bp_remainder", remainder, ref_r(bp_a, bp_b));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 32'd0);
        chk("bp_release_ready", in_ready, 32'd1);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        dividend = 16'hABCD;
        divisor  = 8'h13;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 32'd0);
        chk("mid_rst_quotient", quotient, 32'd0);
        chk("mid_rst_remainder", remainder, 32'd0);
        chk("mid_rst_dbz", div_by_zero, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_result", out_valid, 32'd0);
        run_div("d200_3", 16'd200, 8'd3);

        // Randomized back-to-back stream with random consumer stalls
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < N_RAND && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            dividend  = 16'($urandom);
            divisor   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            in_valid  = (sent < N_RAND);
            out_ready = 1'($urandom);
            if (in_valid && in_ready) begin
                eq_q.push_back(ref_q(dividend, divisor));
                er_q.push_back(ref_r(dividend, divisor));
                ed_q.push_back(divisor == 8'd0);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (eq_q.size() == 0) begin
                    chk("stream_spurious", eq_q.size(), 32'd1);
                end else begin
                    chk("stream_quotient", quotient, eq_q.pop_front());
                    chk("stream_remainder", remainder, er_q.pop_front());
                    chk("stream_dbz", div_by_zero, ed_q.pop_front());
                    got++;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", got, N_RAND);
        chk("stream_leftover", eq_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
